// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake on both sides.
// Define CLA_PIPE_OVF_EN to enable the signed-overflow output; otherwise ovf is tied 0.
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned NG = WIDTH / GROUP;

    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic [NG-1:0]    r_s1_gp;
    logic [NG-1:0]    r_s1_gg;
    logic             r_s1_cin;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_run;
    logic             w_acc;
    logic             w_bc;
    logic             w_s2_free;
    logic             w_s2_load;
    logic             w_s1_load;

    assign w_s2_free = !r_s2_valid | out_ready;
    assign w_s2_load = r_s1_valid & w_s2_free;
    assign in_ready  = !r_s1_valid | w_s2_free;
    assign w_s1_load = in_valid & in_ready;

    assign out_valid = r_s2_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_comb begin
        w_p  = a ^ b;
        w_g  = a & b;
        w_gp = '0;
        w_gg = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            w_gp[k] = 1'b1;
            for (int unsigned m = 0; m < GROUP; m++) begin
                w_gg[k] = w_g[k*GROUP+m] | (w_p[k*GROUP+m] & w_gg[k]);
                w_gp[k] = w_gp[k] & w_p[k*GROUP+m];
            end
        end
    end

    // Each group carry is the flattened sum-of-products over all lower groups and cin,
    // so no group carry depends on another group carry.
    always_comb begin
        w_c    = '0;
        w_c[0] = r_s1_cin;
        w_run  = 1'b0;
        w_acc  = 1'b0;
        w_bc   = 1'b0;
        w_sum  = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            w_run = 1'b1;
            w_acc = 1'b0;
            for (int unsigned j = 0; j <= k; j++) begin
                w_acc = w_acc | (w_run & r_s1_gg[k-j]);
                w_run = w_run & r_s1_gp[k-j];
            end
            w_c[k+1] = w_acc | (w_run & r_s1_cin);
        end
        for (int unsigned k = 0; k < NG; k++) begin
            w_bc = w_c[k];
            for (int unsigned m = 0; m < GROUP; m++) begin
                w_sum[k*GROUP+m] = r_s1_p[k*GROUP+m] ^ w_bc;
                w_bc = r_s1_g[k*GROUP+m] | (r_s1_p[k*GROUP+m] & w_bc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_gp    <= '0;
            r_s1_gg    <= '0;
            r_s1_cin   <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s1_load) begin
                r_s1_p   <= w_p;
                r_s1_g   <= w_g;
                r_s1_gp  <= w_gp;
                r_s1_gg  <= w_gg;
                r_s1_cin <= cin;
            end
            if (w_s2_load) begin
                r_sum  <= w_sum;
                r_cout <= w_c[NG];
            end
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic r_s1_amsb;
    logic r_s1_bmsb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_amsb <= 1'b0;
            r_s1_bmsb <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_amsb <= a[WIDTH-1];
                r_s1_bmsb <= b[WIDTH-1];
            end
            if (w_s2_load) begin
                r_ovf <= (r_s1_amsb == r_s1_bmsb) & (w_sum[WIDTH-1] != r_s1_amsb);
            end
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4): directed cases plus
// random traffic scored against an arithmetic reference queue.
module tb_cla_pipe_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    cla_pipe_adder #(
        .WIDTH(16),
        .GROUP(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    logic        obs_ov, obs_irdy, obs_cout, obs_ovf;
    logic [15:0] obs_sum;
    logic        prev_ov, prev_ordy;
    logic [15:0] prev_sum;
    logic        prev_cout;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] aa, input logic [15:0] bb, input logic cc);
        exp_t        e;
        int unsigned full;
        full = int'(aa) + int'(bb) + int'(cc);
        e.s  = full[15:0];
        e.c  = full[16];
`ifdef CLA_PIPE_OVF_EN
        e.o  = (aa[15] == bb[15]) && (e.s[15] != aa[15]);
`else
        e.o  = 1'b0;
`endif
        return e;
    endfunction

    // One clock cycle: drive at negedge, sample #1 later, score transfers, wait for posedge.
    task automatic step(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                        input logic cc, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        a         = aa;
        b         = bb;
        cin       = cc;
        out_ready = ordy;
        #1;
        obs_ov   = out_valid;
        obs_irdy = in_ready;
        obs_sum  = sum;
        obs_cout = cout;
        obs_ovf  = ovf;
        if (prev_ov && !prev_ordy) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_sum", 64'(sum), 64'(prev_sum));
            check("hold_cout", 64'(cout), 64'(prev_cout));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                check("sb_sum", 64'(sum), 64'(e.s));
                check("sb_cout", 64'(cout), 64'(e.c));
                check("sb_ovf", 64'(ovf), 64'(e.o));
            end
        end
        if (in_valid && in_ready) begin
            q.push_back(model(aa, bb, cc));
            n_acc++;
        end
        prev_ov   = out_valid;
        prev_ordy = out_ready;
        prev_sum  = sum;
        prev_cout = cout;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        prev_ov = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int unsigned cyc;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        prev_ov   = 1'b0;
        prev_ordy = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        do_reset();

        // Two-cycle latency, carry across a group boundary
        step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("first_in_ready", 64'(obs_irdy), 64'd1);
        check("lat1_valid", 64'(obs_ov), 64'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("lat2_valid", 64'(obs_ov), 64'd1);
        check("lat_sum", 64'(obs_sum), 64'h0100);
        check("lat_cout", 64'(obs_cout), 64'd0);
        check("lat_ovf", 64'(obs_ovf), 64'd0);

        // Full carry-chain wrap
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("wrap_sum", 64'(obs_sum), 64'h0000);
        check("wrap_cout", 64'(obs_cout), 64'd1);
        check("wrap_ovf", 64'(obs_ovf), 64'd0);

        // Signed overflow
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("ovf_sum", 64'(obs_sum), 64'h8000);
        check("ovf_cout", 64'(obs_cout), 64'd0);
`ifdef CLA_PIPE_OVF_EN
        check("ovf_flag", 64'(obs_ovf), 64'd1);
`else
        check("ovf_flag", 64'(obs_ovf), 64'd0);
`endif
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("idle_valid", 64'(obs_ov), 64'd0);

        // Back-pressure: two beats fill the pipe, third is held off
        step(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
        step(1'b1, 16'd2, 16'd2, 1'b0, 1'b0);
        check("bp_ready_s1full", 64'(obs_irdy), 64'd1);
        step(1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
        check("bp_ready_full", 64'(obs_irdy), 64'd0);
        check("bp_hold_sum", 64'(obs_sum), 64'h0002);
        step(1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
        check("bp_ready_full2", 64'(obs_irdy), 64'd0);
        check("bp_hold_sum2", 64'(obs_sum), 64'h0002);
        step(1'b1, 16'd3, 16'd3, 1'b0, 1'b1);
        check("bp_ready_release", 64'(obs_irdy), 64'd1);
        check("bp_out0", 64'(obs_sum), 64'h0002);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("bp_out1_valid", 64'(obs_ov), 64'd1);
        check("bp_out1", 64'(obs_sum), 64'h0004);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("bp_out2_valid", 64'(obs_ov), 64'd1);
        check("bp_out2", 64'(obs_sum), 64'h0006);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
        check("bp_drained", 64'(obs_ov), 64'd0);
        check("bp_queue", 64'(q.size()), 64'd0);

        // Reset with both stages full discards everything
        step(1'b1, 16'd5, 16'd5, 1'b0, 1'b0);
        step(1'b1, 16'd6, 16'd6, 1'b0, 1'b0);
        step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        check("pre_rst_valid", 64'(obs_ov), 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
            check("post_rst_valid", 64'(obs_ov), 64'd0);
            check("post_rst_ready", 64'(obs_irdy), 64'd1);
        end

        // Random traffic with random back-pressure
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 40000) begin
            step(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom % 3) != 0);
            cyc++;
        end
        check("rand_accepted", 64'(n_acc), 64'd10000);
        cyc = 0;
        while (q.size() != 0 && cyc < 100) begin
            step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
            cyc++;
        end
        check("rand_drain", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/sum width; legal 4..64, multiple of GROUP.
REQ-002 SHALL have parameter GROUP, default 4, meaning carry-lookahead group size; legal 2, 4 or 8.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 out_valid  output  1  result beat offered.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  a+b+cin, low WIDTH bits.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  signed overflow (see Configuration).

Function
REQ-015 Transfer occurs on a rising edge where valid and ready are both 1, on input and output sides independently.
REQ-016 Two-stage pipeline: S1 registers per-bit propagate/generate, per-group P/G, operand MSBs and cin; S2 registers sum, cout, ovf.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid=1 when out_ready is held 1.
REQ-018 Throughput SHALL be one beat per cycle with out_ready held 1.
REQ-019 Group carries SHALL use lookahead: c[k+1] = G[k] | P[k]&c[k]; in-group bit carries likewise; no ripple across groups in one stage.
REQ-020 Result SHALL equal (a+b+cin) mod 2^WIDTH with cout = bit WIDTH of the full sum, for all operand values.
REQ-021 S2 loads when S1 valid and (S2 empty or out_ready); S1 loads when in_valid and (S1 empty or S1 advancing).
REQ-022 in_ready SHALL be !s1_valid | (!s2_valid | out_ready); combinational from out_ready, no path from in_valid.
REQ-023 With out_ready=0 and both stages full, in_ready SHALL be 0 and sum/cout/ovf/out_valid SHALL hold stable.
REQ-024 Once out_valid=1 it SHALL stay 1 with unchanged data until transfer.
REQ-025 Simultaneous output transfer and input transfer with both stages full SHALL move S1->S2 and new beat->S1 in one cycle, no loss or duplication.
REQ-026 Beats SHALL emerge in acceptance order.
REQ-027 a=all-ones, b=0, cin=1 SHALL give sum=0, cout=1 (full carry chain wrap).

Reset
REQ-028 rst_n=0 SHALL immediately clear s1_valid and s2_valid; out_valid=0, sum=0, cout=0, ovf=0.
REQ-029 in_ready SHALL be 1 while rst_n=0 and on the first cycle after release.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none emitted after release.
REQ-031 Datapath registers SHALL also reset to 0.

Configuration
REQ-032 Macro CLA_PIPE_OVF_EN: when defined, ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), pipelined with sum, same latency.
REQ-033 Without CLA_PIPE_OVF_EN, ovf port SHALL remain and be tied 0; no overflow registers synthesised.

Verification (WIDTH=16, GROUP=4)
REQ-034 a=0x00FF, b=0x0001, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x0100, cout=0, ovf=0.
REQ-035 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
REQ-036 CLA_PIPE_OVF_EN defined: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; without macro ovf=0.
REQ-037 3 back-to-back beats (1+1, 2+2, 3+3), out_ready=0 for cycles 2..5 -> in_ready=0 after 2 accepted, outputs hold 0x0002; then out_ready=1 -> 0x0002, 0x0004, 0x0006 in order, none lost.
REQ-038 Assert rst_n=0 with both stages full -> out_valid=0 immediately; after release no stale beat appears, in_ready=1.
REQ-039 10,000 random beats with random out_ready -> every sum/cout matches reference model, order preserved.
